// File: rtl/alu_seq_control.sv
// Vector ALU sequencer: splits one vector instruction into lane-group phases,
// drives operand selects / result strobes and maps the opcode to the lane ALU.
module alu_seq_control #(
  parameter  int NUM_ELEMS = 8,
  parameter  int LANES     = 4,
  localparam int PHASES    = (NUM_ELEMS + LANES - 1) / LANES,
  localparam int PW        = (PHASES > 1) ? $clog2(PHASES) : 1,
  localparam int SW        = $clog2(PHASES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_start,
  input  logic [3:0]        alu_op,
  input  logic              alu_stall,
  output logic              alu_busy,
  output logic              alu_rdy,
  output logic              alu_err,
  output logic [PHASES-1:0] out_en,
  output logic [PW-1:0]     in_sel_a,
  output logic [SW-1:0]     in_sel_b,
  output logic [3:0]        int_alu_op
);

  localparam logic [3:0] OP_SUM    = 4'd0;
  localparam logic [3:0] OP_SUBS   = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd5;
  localparam logic [3:0] OP_LSHIFT = 4'd6;
  localparam logic [3:0] OP_RSHIFT = 4'd7;
  localparam logic [3:0] OP_LROT   = 4'd9;
  localparam logic [3:0] OP_RROT   = 4'd10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [PW-1:0] ph_q;
  logic [3:0]    op_q;
  logic          run, scalar;

  function automatic logic illegal(input logic [3:0] op);
    return op[3:1] == 3'b111;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ph_q    <= '0;
      op_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (alu_start) begin
          op_q    <= alu_op;
          ph_q    <= '0;
          state_q <= illegal(alu_op) ? DONE : RUN;
        end
        RUN: if (!alu_stall) begin
          // Last phase leaves straight to DONE; the counter never wraps.
          if (ph_q == PW'(PHASES - 1)) state_q <= DONE;
          else                         ph_q    <= ph_q + 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign run      = (state_q == RUN);
  assign alu_busy = (state_q != IDLE);
  assign alu_rdy  = (state_q == DONE);
  assign alu_err  = alu_rdy & illegal(op_q);
  assign in_sel_a = run ? ph_q : '0;

  for (genvar g = 0; g < PHASES; g++) begin : g_en
    assign out_en[g] = run & ~alu_stall & (ph_q == PW'(g));
  end

  always_comb begin
    scalar = 1'b0;
    case (op_q)
      4'b0000, 4'b0010, 4'b0100, 4'b1011, 4'b1101: scalar = 1'b1;
      default:                                     scalar = 1'b0;
    endcase
  end

  // Select value PHASES routes the scalar broadcast into the B operand.
  always_comb begin
    in_sel_b = '0;
    if (alu_busy && scalar) in_sel_b = SW'(PHASES);
    else if (run)           in_sel_b = SW'(ph_q);
  end

  always_comb begin
    int_alu_op = OP_OR;
    case (op_q)
      4'b0000, 4'b0001: int_alu_op = OP_AND;
      4'b0010, 4'b0011: int_alu_op = OP_OR;
      4'b0100, 4'b0101: int_alu_op = OP_XOR;
      4'b0110:          int_alu_op = OP_RSHIFT;
      4'b0111:          int_alu_op = OP_LSHIFT;
      4'b1000:          int_alu_op = OP_RROT;
      4'b1001:          int_alu_op = OP_LROT;
      4'b1010, 4'b1011: int_alu_op = OP_SUM;
      4'b1100, 4'b1101: int_alu_op = OP_SUBS;
      default:          int_alu_op = OP_OR;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_control.sv
// Scoreboard bench for alu_seq_control: default (2-phase) and 16/4 (4-phase) instances.
module tb_alu_seq_control;

  typedef struct packed {
    logic [3:0] en;
    logic [1:0] sa;
    logic [2:0] sb;
    logic [3:0] iop;
    logic       busy, rdy, err;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, a_start = 1'b0, a_stall = 1'b0;
  logic [3:0] a_op = '0;
  logic       a_busy, a_rdy, a_err;
  logic [1:0] a_en, a_sb;
  logic [0:0] a_sa;
  logic [3:0] a_iop;

  logic       b_rst = 1'b1, b_start = 1'b0, b_stall = 1'b0;
  logic [3:0] b_op = '0;
  logic       b_busy, b_rdy, b_err;
  logic [3:0] b_en;
  logic [1:0] b_sa;
  logic [2:0] b_sb;
  logic [3:0] b_iop;

  alu_seq_control dut_a (
    .clk(clk), .reset(a_rst), .alu_start(a_start), .alu_op(a_op), .alu_stall(a_stall),
    .alu_busy(a_busy), .alu_rdy(a_rdy), .alu_err(a_err), .out_en(a_en),
    .in_sel_a(a_sa), .in_sel_b(a_sb), .int_alu_op(a_iop));

  alu_seq_control #(.NUM_ELEMS(16), .LANES(4)) dut_b (
    .clk(clk), .reset(b_rst), .alu_start(b_start), .alu_op(b_op), .alu_stall(b_stall),
    .alu_busy(b_busy), .alu_rdy(b_rdy), .alu_err(b_err), .out_en(b_en),
    .in_sel_a(b_sa), .in_sel_b(b_sb), .int_alu_op(b_iop));

  logic sel = 1'b0;
  rec_t obs;
  always_comb begin
    obs = '0;
    if (sel) begin
      obs.en = b_en; obs.sa = b_sa; obs.sb = b_sb; obs.iop = b_iop;
      obs.busy = b_busy; obs.rdy = b_rdy; obs.err = b_err;
    end else begin
      obs.en = {2'b00, a_en}; obs.sa = {1'b0, a_sa}; obs.sb = {1'b0, a_sb}; obs.iop = a_iop;
      obs.busy = a_busy; obs.rdy = a_rdy; obs.err = a_err;
    end
  end

  rec_t q[$];
  int   errors = 0, checks = 0;
  int   last_iop[2] = '{2, 2};

  function automatic rec_t mk(input int en, input int sa, input int sb, input int io,
                              input bit bz, input bit rd, input bit er);
    rec_t r;
    r.en = 4'(en); r.sa = 2'(sa); r.sb = 3'(sb); r.iop = 4'(io);
    r.busy = bz; r.rdy = rd; r.err = er;
    return r;
  endfunction

  // Drive one cycle's inputs, compare outputs against the next scoreboard entry, advance.
  task automatic cyc(input logic s, input string tag, input int idx, input logic rst,
                     input logic st, input logic [3:0] op, input logic stl);
    rec_t e;
    if (s) begin b_rst = rst; b_start = st; b_op = op; b_stall = stl; end
    else   begin a_rst = rst; a_start = st; a_op = op; a_stall = stl; end
    sel = s;
    #1;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s cyc%0d: scoreboard empty", tag, idx);
    end else begin
      e = q.pop_front();
      if (obs !== e)
        begin
          errors++;
          $display("FAIL %s cyc%0d: got en=%b sa=%0d sb=%0d op=%0d busy=%b rdy=%b err=%b, exp en=%b sa=%0d sb=%0d op=%0d busy=%b rdy=%b err=%b",
                   tag, idx, obs.en, obs.sa, obs.sb, obs.iop, obs.busy, obs.rdy, obs.err,
                   e.en, e.sa, e.sb, e.iop, e.busy, e.rdy, e.err);
        end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset(input logic s);
    q.push_back(mk(0, 0, 0, 2, 0, 0, 0));
    cyc(s, "reset", 0, 1'b0, 1'b0, 4'h0, 1'b0);
    last_iop[s] = 2;
  endtask

  // Start one operation; expected records come from the phase timing and stall pattern.
  task automatic run_op(input logic s, input string tag, input logic [3:0] op,
                        input logic [7:0] stalls, input logic scalar, input int iop,
                        input logic ill);
    int  P = s ? 4 : 2;
    int  ph = 0, j = 0, n;
    logic stl;
    q.push_back(mk(0, 0, 0, last_iop[s], 0, 0, 0));
    if (ill) q.push_back(mk(0, 0, 0, iop, 1, 1, 1));
    else begin
      while (ph < P) begin
        stl = stalls[j];
        q.push_back(mk(stl ? 0 : (1 << ph), ph, scalar ? P : ph, iop, 1, 0, 0));
        if (!stl) ph++;
        j++;
      end
      q.push_back(mk(0, 0, scalar ? P : 0, iop, 1, 1, 0));
    end
    q.push_back(mk(0, 0, 0, iop, 0, 0, 0));
    n = q.size();
    for (int i = 0; i < n; i++)
      cyc(s, tag, i, 1'b0, i == 0, (i == 0) ? op : ~op,
          (i >= 1 && i <= j) ? stalls[i-1] : 1'b0);
    last_iop[s] = iop;
  endtask

  task automatic test_reset_midrun();
    q.push_back(mk(0, 0, 0, last_iop[1], 0, 0, 0));
    q.push_back(mk(1, 0, 0, 9, 1, 0, 0));
    q.push_back(mk(2, 1, 1, 9, 1, 0, 0));
    q.push_back(mk(4, 2, 2, 9, 1, 0, 0));
    for (int i = 0; i < 4; i++) q.push_back(mk(0, 0, 0, 2, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      cyc(1'b1, "reset_midrun", i, i == 3, i == 0, (i == 0) ? 4'b1001 : 4'b0000, 1'b0);
    last_iop[1] = 2;
  endtask

  task automatic test_reset_start();
    q.push_back(mk(0, 0, 0, last_iop[0], 0, 0, 0));
    q.push_back(mk(0, 0, 0, 2, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 2, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      cyc(1'b0, "reset_start", i, i == 0, i == 0, 4'b0111, 1'b0);
    last_iop[0] = 2;
  endtask

  // Start held high: new ops only at the IDLE cycles, illegal opcode shown while busy.
  task automatic test_back_to_back();
    q.push_back(mk(0, 0, 0, last_iop[0], 0, 0, 0));
    for (int r = 0; r < 3; r++) begin
      q.push_back(mk(1, 0, 0, 5, 1, 0, 0));
      q.push_back(mk(2, 1, 1, 5, 1, 0, 0));
      q.push_back(mk(0, 0, 0, 5, 1, 1, 0));
      q.push_back(mk(0, 0, 0, 5, 0, 0, 0));
    end
    for (int i = 0; i < 13; i++)
      cyc(1'b0, "back_to_back", i, 1'b0, i != 12, (i % 4 == 0) ? 4'b0101 : 4'b1111, 1'b0);
    last_iop[0] = 5;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset(1'b0);
    test_reset(1'b1);
    run_op(1'b0, "vv_and",   4'b0001, 8'h00, 1'b0, 2, 1'b0);
    run_op(1'b0, "sve",      4'b1011, 8'h00, 1'b1, 0, 1'b0);
    run_op(1'b0, "stall",    4'b1100, 8'h01, 1'b0, 1, 1'b0);
    run_op(1'b0, "illegal",  4'b1111, 8'h00, 1'b0, 3, 1'b1);
    run_op(1'b0, "rshift",   4'b0110, 8'h06, 1'b0, 7, 1'b0);
    run_op(1'b0, "orve",     4'b0010, 8'h02, 1'b1, 3, 1'b0);
    run_op(1'b0, "illegal2", 4'b1110, 8'h00, 1'b0, 3, 1'b1);
    test_back_to_back();
    test_reset_start();
    run_op(1'b1, "lrot",     4'b1001, 8'h00, 1'b0, 9, 1'b0);
    run_op(1'b1, "rve",      4'b1101, 8'h05, 1'b1, 1, 1'b0);
    test_reset_midrun();
    run_op(1'b1, "xore",     4'b0100, 8'h00, 1'b1, 5, 1'b0);
    run_op(1'b1, "rrot",     4'b1000, 8'h00, 1'b0, 10, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
